// File: rtl/xbar_input_arbiter.sv
// Round-robin input arbiter for a blocking crossbar.
// Issues the control word, then gates the granted source for a burst.
module xbar_input_arbiter #(
  parameter int BIT_WIDTH         = 32,
  parameter int N_INPUTS          = 2,
  parameter int N_OUTPUTS         = 2,
  parameter int CONTROL_BIT_WIDTH = 42,
  parameter int MAX_BURST         = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_INPUTS*BIT_WIDTH-1:0]   src_msg,
  input  logic [N_INPUTS-1:0]             src_val,
  output logic [N_INPUTS-1:0]             src_rdy,
  output logic [N_INPUTS*BIT_WIDTH-1:0]   xbar_msg,
  output logic [N_INPUTS-1:0]             xbar_val,
  input  logic [N_INPUTS-1:0]             xbar_rdy,
  output logic [CONTROL_BIT_WIDTH-1:0]    control,
  output logic                            control_val,
  input  logic                            control_rdy
);

  localparam int IW = $clog2(N_INPUTS);
  localparam int DW = $clog2(N_OUTPUTS);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] prio_ptr;
  logic [IW-1:0] grant_in;
  logic [DW-1:0] grant_out;
  logic [BW-1:0] burst_cnt;

  logic [DW-1:0] dest [N_INPUTS];
  logic [IW-1:0] winner;
  logic [IW-1:0] idx;
  logic [IW-1:0] next_ptr;
  logic          found;
  logic          g_val;
  logic          g_rdy;
  logic          match;
  logic          fire;
  logic          last;
  logic          rel;

  // Modular increment without assuming N_INPUTS is a power of two
  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] a,
    input int            k
  );
    int s;
    s = int'(a) + k;
    if (s >= N_INPUTS) s = s - N_INPUTS;
    return IW'(s);
  endfunction

  assign xbar_msg = src_msg;

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      dest[i] = src_msg[i*BIT_WIDTH+BIT_WIDTH-1 -: DW];
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      idx = wrap_add(prio_ptr, k);
      if (!found && src_val[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign next_ptr = wrap_add(grant_in, 1);
  assign g_val    = src_val[grant_in];
  assign g_rdy    = xbar_rdy[grant_in];
  assign match    = dest[grant_in] == grant_out;
  assign fire     = (state == XFER) && g_val && g_rdy && match;
  assign last     = burst_cnt == BW'(MAX_BURST - 1);
  assign rel      = (fire && last) || !g_val || !match;

  // Outputs are held quiet while reset is asserted
  always_comb begin
    src_rdy     = '0;
    xbar_val    = '0;
    control_val = 1'b0;
    control     = '0;
    if (reset) begin
      if (state == IDLE) begin
        control_val = found;
        if (found) begin
          control[CONTROL_BIT_WIDTH-1 -: IW]    = winner;
          control[CONTROL_BIT_WIDTH-1-IW -: DW] = dest[winner];
        end
      end else begin
        xbar_val[grant_in] = g_val && match;
        src_rdy[grant_in]  = g_rdy && match;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      grant_in  <= '0;
      grant_out <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found && control_rdy) begin
            grant_in  <= winner;
            grant_out <= dest[winner];
            burst_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (fire) burst_cnt <= burst_cnt + 1'b1;
          if (rel) begin
            prio_ptr <= next_ptr;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_input_arbiter.sv
// Directed bench for xbar_input_arbiter with source queues
// and a transfer scoreboard checked at the crossbar side.
module tb_xbar_input_arbiter;

  logic        clk;
  logic        reset;
  logic [63:0] src_msg;
  logic [1:0]  src_val;
  logic [1:0]  src_rdy;
  logic [63:0] xbar_msg;
  logic [1:0]  xbar_val;
  logic [1:0]  xbar_rdy;
  logic [41:0] control;
  logic        control_val;
  logic        control_rdy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [32:0] sb [$];
  logic [32:0] mon_exp;
  logic [32:0] mon_obs;

  xbar_input_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .src_msg     (src_msg),
    .src_val     (src_val),
    .src_rdy     (src_rdy),
    .xbar_msg    (xbar_msg),
    .xbar_val    (xbar_val),
    .xbar_rdy    (xbar_rdy),
    .control     (control),
    .control_val (control_val),
    .control_rdy (control_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int d, input int i, input int s);
    logic [31:0] m;
    m = {d[0], i[6:0], s[23:0]};
    return m;
  endfunction

  function automatic logic [41:0] ctl(input int i, input int o);
    logic [41:0] c;
    c = '0;
    c[41] = i[0];
    c[40] = o[0];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    src_val[0]     = q0.size() != 0;
    src_val[1]     = q1.size() != 0;
    src_msg[31:0]  = (q0.size() != 0) ? q0[0] : 32'h0;
    src_msg[63:32] = (q1.size() != 0) ? q1[0] : 32'h0;
  endtask

  task automatic tick();
    logic [1:0] f;
    f = src_val & src_rdy;
    @(posedge clk);
    #1;
    if (f[0]) void'(q0.pop_front());
    if (f[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic nxt();
    tick();
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag, input int i, input int o);
    chk({tag, "_cval"}, 64'(control_val), 64'd1);
    chk({tag, "_ctl"}, 64'(control), 64'(ctl(i, o)));
    chk({tag, "_srdy"}, 64'(src_rdy), 64'd0);
    chk({tag, "_xval"}, 64'(xbar_val), 64'd0);
  endtask

  task automatic xfer_chk(input string tag, input logic [1:0] v,
                          input logic [1:0] r);
    chk({tag, "_cval"}, 64'(control_val), 64'd0);
    chk({tag, "_xval"}, 64'(xbar_val), 64'(v));
    chk({tag, "_srdy"}, 64'(src_rdy), 64'(r));
  endtask

  task automatic rel_chk(input string tag);
    chk({tag, "_cval"}, 64'(control_val), 64'd0);
    chk({tag, "_xval"}, 64'(xbar_val), 64'd0);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_cval"}, 64'(control_val), 64'd0);
    chk({tag, "_ctl"}, 64'(control), 64'd0);
    chk({tag, "_srdy"}, 64'(src_rdy), 64'd0);
    chk({tag, "_xval"}, 64'(xbar_val), 64'd0);
  endtask

  // Crossbar-side scoreboard: every captured message must be next in order
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (xbar_val[i] && xbar_rdy[i]) begin
          n_cmp++;
          assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL sb_empty: transfer on input %0d, expected none", i);
          end
          if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            mon_obs = {i[0], xbar_msg[i*32 +: 32]};
            assert (mon_obs === mon_exp) else begin
              n_bad++;
              $error("FAIL sb_xfer: got %0h expected %0h", mon_obs, mon_exp);
            end
          end
        end
      end
    end
  end

  initial begin
    int g;
    reset       = 1'b0;
    control_rdy = 1'b1;
    xbar_rdy    = 2'b11;
    q1.push_back(mk(1, 1, 1));
    drive();

    // Reset: outputs quiet even with a valid source
    @(negedge clk);
    zero_chk("rst0");
    nxt();
    zero_chk("rst1");
    tick();
    reset = 1'b1;
    @(negedge clk);

    // Single source, dest 1
    idle_chk("single_idle", 1, 1);
    chk("passthru", xbar_msg, src_msg);
    sb.push_back({1'b1, q1[0]});
    nxt();
    xfer_chk("single_xfer", 2'b10, 2'b10);
    nxt();
    rel_chk("single_rel");

    // Contention: both back-to-back, bursts of 4 alternate
    for (int s = 0; s < 8; s++) begin
      q0.push_back(mk(0, 0, 16 + s));
      q1.push_back(mk(1, 1, 32 + s));
    end
    for (int h = 0; h < 2; h++) begin
      for (int s = 0; s < 4; s++) sb.push_back({1'b0, q0[h*4+s]});
      for (int s = 0; s < 4; s++) sb.push_back({1'b1, q1[h*4+s]});
    end
    nxt();
    for (int c = 0; c < 20; c++) begin
      g = (c / 5) % 2;
      if (c % 5 == 0) idle_chk("cont_idle", g, g);
      else xfer_chk("cont_xfer", 2'(1 << g), 2'(1 << g));
      nxt();
    end
    chk("cont_done_cval", 64'(control_val), 64'd0);

    // Destination change after two messages
    q0.push_back(mk(0, 0, 64));
    q0.push_back(mk(0, 0, 65));
    q0.push_back(mk(1, 0, 66));
    sb.push_back({1'b0, q0[0]});
    sb.push_back({1'b0, q0[1]});
    sb.push_back({1'b0, q0[2]});
    nxt();
    idle_chk("dest_idle0", 0, 0);
    nxt();
    xfer_chk("dest_f0", 2'b01, 2'b01);
    nxt();
    xfer_chk("dest_f1", 2'b01, 2'b01);
    nxt();
    xfer_chk("dest_rel", 2'b00, 2'b00);
    nxt();
    idle_chk("dest_idle1", 0, 1);
    nxt();
    xfer_chk("dest_f2", 2'b01, 2'b01);
    nxt();
    rel_chk("dest_end");

    // Back-pressure on input 1 for 5 cycles
    xbar_rdy = 2'b01;
    for (int s = 0; s < 5; s++) begin
      q1.push_back(mk(1, 1, 80 + s));
      sb.push_back({1'b1, mk(1, 1, 80 + s)});
    end
    nxt();
    idle_chk("bp_idle", 1, 1);
    for (int c = 0; c < 5; c++) begin
      nxt();
      xfer_chk("bp_stall", 2'b10, 2'b00);
    end
    tick();
    xbar_rdy = 2'b11;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      xfer_chk("bp_fire", 2'b10, 2'b10);
      nxt();
    end
    idle_chk("bp_regrant", 1, 1);
    nxt();
    xfer_chk("bp_last", 2'b10, 2'b10);
    nxt();
    rel_chk("bp_end");

    // Control not accepted for 3 cycles
    control_rdy = 1'b0;
    q0.push_back(mk(1, 0, 96));
    q0.push_back(mk(1, 0, 97));
    sb.push_back({1'b0, q0[0]});
    sb.push_back({1'b0, q0[1]});
    nxt();
    for (int c = 0; c < 3; c++) begin
      idle_chk("crdy_hold", 0, 1);
      if (c < 2) nxt();
    end
    tick();
    control_rdy = 1'b1;
    @(negedge clk);
    idle_chk("crdy_accept", 0, 1);
    nxt();
    xfer_chk("crdy_f0", 2'b01, 2'b01);
    nxt();
    xfer_chk("crdy_f1", 2'b01, 2'b01);
    nxt();
    rel_chk("crdy_end");

    // Reset mid-burst at burst_cnt=2
    for (int s = 0; s < 3; s++) q1.push_back(mk(0, 1, 112 + s));
    sb.push_back({1'b1, q1[0]});
    sb.push_back({1'b1, q1[1]});
    nxt();
    idle_chk("mrst_idle", 1, 0);
    nxt();
    xfer_chk("mrst_f0", 2'b10, 2'b10);
    nxt();
    xfer_chk("mrst_f1", 2'b10, 2'b10);
    tick();
    reset = 1'b0;
    @(negedge clk);
    zero_chk("mrst_hold");
    nxt();
    zero_chk("mrst_after");
    q0.push_back(mk(1, 0, 128));
    sb.push_back({1'b0, q0[0]});
    sb.push_back({1'b1, q1[0]});
    tick();
    reset = 1'b1;
    @(negedge clk);
    idle_chk("mrst_ptr0", 0, 1);
    nxt();
    xfer_chk("mrst_in0", 2'b01, 2'b01);
    nxt();
    rel_chk("mrst_rel0");
    nxt();
    idle_chk("mrst_in1_idle", 1, 0);
    nxt();
    xfer_chk("mrst_in1", 2'b10, 2'b10);
    nxt();
    rel_chk("mrst_rel1");
    nxt();

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
